// File: rtl/phoneme_queue_responder_pkg.sv
// Shared definitions for the phoneme queue responder: register offsets,
// STATUS/CTRL bit positions and the drain FSM states.
package phq_pkg;

  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_THRESH = 3'd3;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } drain_state_t;

endpackage

// File: rtl/phoneme_queue_responder_if.sv
// 68000-style CPU bus seen by the phoneme queue responder.
interface phoneme_queue_responder_if;
  logic        Select_H;
  logic        AS_L;
  logic        UDS_L;
  logic        LDS_L;
  logic        RW;
  logic [2:0]  Address;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Dtack_L;

  modport master (
    output Select_H, AS_L, UDS_L, LDS_L, RW, Address, DataIn,
    input  DataOut, Dtack_L
  );

  modport slave (
    input  Select_H, AS_L, UDS_L, LDS_L, RW, Address, DataIn,
    output DataOut, Dtack_L
  );
endinterface

// File: rtl/phoneme_queue_responder_sync_fifo.sv
// Single-clock 8-bit FIFO holding queued phoneme codes; flush empties it.
module phq_sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [7:0]             wdata,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
    end
  end

endmodule

// File: rtl/phoneme_queue_responder.sv
// Memory-mapped phoneme queue: CPU writes phonemes, a drain FSM feeds the synthesiser.
// Optional low-water interrupt enabled by defining PHQ_IRQ_EN.
module phoneme_queue_responder
  import phq_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  phoneme_queue_responder_if.slave   bus,
  output logic [7:0]                 phoneme_sel,
  output logic                       start_phoneme_output,
  input  logic                       phoneme_speech_busy,
  output logic                       IRQ_L
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  logic [SYNC_STAGES-1:0] as_chain;
  logic [SYNC_STAGES-1:0] uds_chain;
  logic [SYNC_STAGES-1:0] lds_chain;
  logic                   as_s;
  logic                   uds_s;
  logic                   lds_s;
  logic                   as_prev;

  logic                   access_start;
  logic                   active;
  logic                   wr_strobe;
  logic                   push_req;
  logic                   ctrl_write;
  logic                   thresh_write;
  logic                   ovf_set;
  logic                   overflow;
  logic                   clr_ovf_pending;
  logic                   flush;
  logic                   irq_en;
  logic [7:0]             thresh;
  logic [15:0]            read_value;
  logic [15:0]            count_ext;

  logic [7:0]             head;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   empty;
  logic                   pop;

  drain_state_t           state;
  logic [TW-1:0]          timer;

  // Chains reset to the asserted level so a strobe already low at reset
  // release never looks like a fresh falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      as_chain  <= '0;
      uds_chain <= '0;
      lds_chain <= '0;
      as_prev   <= 1'b0;
    end else begin
      as_chain  <= {as_chain[SYNC_STAGES-2:0], bus.AS_L};
      uds_chain <= {uds_chain[SYNC_STAGES-2:0], bus.UDS_L};
      lds_chain <= {lds_chain[SYNC_STAGES-2:0], bus.LDS_L};
      as_prev   <= as_s;
    end
  end

  assign as_s  = as_chain[SYNC_STAGES-1];
  assign uds_s = uds_chain[SYNC_STAGES-1];
  assign lds_s = lds_chain[SYNC_STAGES-1];

  assign access_start = bus.Select_H && as_prev && !as_s;
  assign wr_strobe    = !uds_s || !lds_s;
  assign push_req     = access_start && !bus.RW && (bus.Address == REG_DATA) && !lds_s;
  assign ctrl_write   = access_start && !bus.RW && wr_strobe && (bus.Address == REG_CTRL);
  assign thresh_write = access_start && !bus.RW && wr_strobe && (bus.Address == REG_THRESH);
  assign pop          = (state == LOAD) && !empty;
  assign ovf_set      = push_req && full && !pop;
  assign count_ext    = 16'(count);

  phq_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .flush (flush),
    .wdata (bus.DataIn[7:0]),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    read_value = '0;
    case (bus.Address)
      REG_DATA:   read_value = {8'h00, head};
      REG_STATUS: begin
        read_value[STAT_EMPTY]           = empty;
        read_value[STAT_FULL]            = full;
        read_value[STAT_BUSY]            = (state != IDLE);
        read_value[STAT_OVERFLOW]        = overflow;
        read_value[STAT_COUNT_LSB +: 8]  = count_ext[7:0];
      end
      REG_CTRL:   read_value[CTRL_IRQ_EN] = irq_en;
      REG_THRESH: read_value = {8'h00, thresh};
      default:    read_value = '0;
    endcase
  end

  // Dtack and read data are captured once at access start and held until
  // the strobe is released, so a long AS_L never repeats the side effects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.Dtack_L     <= 1'b1;
      bus.DataOut     <= '0;
      active          <= 1'b0;
      overflow        <= 1'b0;
      clr_ovf_pending <= 1'b0;
      flush           <= 1'b0;
      thresh          <= '0;
    end else begin
      flush           <= 1'b0;
      clr_ovf_pending <= 1'b0;
      if (access_start) begin
        active      <= 1'b1;
        bus.Dtack_L <= 1'b0;
        bus.DataOut <= bus.RW ? read_value : 16'h0000;
        if (bus.RW && (bus.Address == REG_STATUS)) clr_ovf_pending <= 1'b1;
        if (ctrl_write)   flush  <= bus.DataIn[CTRL_FLUSH];
        if (thresh_write) thresh <= bus.DataIn[7:0];
      end else if (active && as_s) begin
        active      <= 1'b0;
        bus.Dtack_L <= 1'b1;
        bus.DataOut <= '0;
      end
      if (ovf_set)              overflow <= 1'b1;
      else if (clr_ovf_pending) overflow <= 1'b0;
    end
  end

  // A phoneme whose busy never arrives is abandoned after the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      phoneme_sel          <= '0;
      start_phoneme_output <= 1'b0;
      timer                <= '0;
    end else begin
      start_phoneme_output <= 1'b0;
      case (state)
        IDLE: if (!empty) state <= LOAD;
        LOAD: begin
          if (!empty) begin
            phoneme_sel          <= head;
            start_phoneme_output <= 1'b1;
            timer                <= '0;
            state                <= WAIT_BUSY;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_BUSY: begin
          if (phoneme_speech_busy)       state <= WAIT_DONE;
          else if (timer == TIMER_LAST)  state <= IDLE;
          else                           timer <= timer + TIMER_ONE;
        end
        WAIT_DONE: if (!phoneme_speech_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef PHQ_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en <= 1'b0;
      IRQ_L  <= 1'b1;
    end else begin
      if (ctrl_write) irq_en <= bus.DataIn[CTRL_IRQ_EN];
      IRQ_L <= !(irq_en && (count_ext <= 16'(thresh)) &&
                 ((state == IDLE) || (state == WAIT_DONE)));
    end
  end
`else
  assign irq_en = 1'b0;
  assign IRQ_L  = 1'b1;
`endif

endmodule
